// File: rtl/ctrl_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle accumulator CPU controller.
package ctrl_unit_mc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StPcUpd,
      StHalt
   } state_e;

   // Opcodes 1..7 are ALU operations; 12..14 are undefined.
   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LD   = 4'd8;
   localparam logic [3:0] OP_ST   = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
   localparam logic [3:0] OP_BZ   = 4'd11;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_LOAD = 2'b10;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op != OP_NOP) && (op[3] == 1'b0);
   endfunction

endpackage

// File: rtl/ir_reg_param.sv
// Instruction register with load enable and synchronous active-low reset.
module ir_reg_param #(
   parameter int unsigned INS_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [INS_W-1:0] d,
   output logic [INS_W-1:0] q
);

   // Capture the fetched word; cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit: fetch over a req/valid handshake, decode and
// sequence the datapath through execute, memory, write-back and PC update.
// Field layout requires ADDR_W + 4 + RD_W <= INS_W.
module ctrl_unit_mc import ctrl_unit_mc_pkg::*; #(
   parameter int unsigned INS_W   = 16,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned NREG    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ram_valid,
   input  logic [INS_W-1:0]  ins,
   input  logic              alu_valid,
   input  logic              alu_zero,
   output logic              ram_rd_req,
   output logic              ram_wr_req,
   output logic [ADDR_W-1:0] offset_addr,
   output logic [NREG-1:0]   reg_en,
   output logic              alu_in_sel,
   output logic [2:0]        alu_func,
   output logic [1:0]        pc_ctrl,
   output logic              en_pc_pulse,
   output logic              en_group_pulse,
   output logic              busy,
   output logic              halted,
   output logic              illegal_op,
   output logic              mem_timeout
);

   localparam int unsigned RD_W  = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [1:0]        pc_sel_q, pc_sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [INS_W-1:0]  ir_q;
   logic              ir_load;
   logic [3:0]        opcode;
   logic [RD_W-1:0]   rd;
   logic              rd_ok;
   logic              wait_expired;
   logic              unused_ir;

   ir_reg_param #(
      .INS_W(INS_W)
   ) u_ir (
      .clk  (clk),
      .rst  (rst),
      .load (ir_load),
      .d    (ins),
      .q    (ir_q)
   );

   assign opcode       = ir_q[INS_W-1 -: 4];
   assign rd           = ir_q[INS_W-5 -: RD_W];
   assign offset_addr  = ir_q[ADDR_W-1:0];
   assign alu_func     = opcode[2:0];
   assign unused_ir    = ^ir_q;
   assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign busy         = (state_q != StIdle) && (state_q != StHalt);
   assign halted       = (state_q == StHalt);
   assign alu_in_sel   = (opcode == OP_LD) &&
                         (state_q inside {StDecode, StExec, StMem, StWb, StPcUpd});

   // Only a non-power-of-two register count can encode an out-of-range rd.
   if (NREG == (1 << RD_W)) begin : g_rd_full
      assign rd_ok = 1'b1;
   end else begin : g_rd_partial
      assign rd_ok = (32'(rd) < NREG);
   end

   // State, pending PC action and RAM wait counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         pc_sel_q <= PC_HOLD;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_sel_q <= pc_sel_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d        = state_q;
      pc_sel_d       = pc_sel_q;
      cnt_d          = '0;
      ir_load        = 1'b0;
      ram_rd_req     = 1'b0;
      ram_wr_req     = 1'b0;
      reg_en         = '0;
      pc_ctrl        = PC_HOLD;
      en_pc_pulse    = 1'b0;
      en_group_pulse = 1'b0;
      illegal_op     = 1'b0;
      mem_timeout    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               en_group_pulse = 1'b1;
               pc_sel_d       = PC_INC;
               state_d        = StFetch;
            end
         end
         StFetch: begin
            ram_rd_req = 1'b1;
            if (ram_valid) begin
               ir_load = 1'b1;
               state_d = StDecode;
            end else if (wait_expired) begin
               mem_timeout = 1'b1;  // counter restarts, request stays up
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDecode: begin
            pc_sel_d = PC_INC;
            if (is_alu_op(opcode)) begin
               illegal_op = !rd_ok;
               state_d    = StExec;
            end else begin
               case (opcode)
                  OP_NOP:  state_d = StPcUpd;
                  OP_LD: begin
                     illegal_op = !rd_ok;
                     state_d    = StMem;
                  end
                  OP_ST:   state_d = StMem;
                  OP_JMP: begin
                     pc_sel_d = PC_LOAD;
                     state_d  = StPcUpd;
                  end
                  OP_BZ:   state_d = StExec;
                  OP_HALT: state_d = StHalt;
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = StPcUpd;
                  end
               endcase
            end
         end
         StExec: begin
            if (alu_valid) begin
               if (opcode == OP_BZ) begin
                  pc_sel_d = alu_zero ? PC_LOAD : PC_INC;
                  state_d  = StPcUpd;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StMem: begin
            if (opcode == OP_ST) begin
               ram_wr_req = 1'b1;
               state_d    = StPcUpd;
            end else begin
               ram_rd_req = 1'b1;
               if (ram_valid) begin
                  state_d = StWb;
               end else if (wait_expired) begin
                  mem_timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StWb: begin
            if (rd_ok) begin
               reg_en = NREG'(1) << rd;
            end
            state_d = StPcUpd;
         end
         StPcUpd: begin
            en_pc_pulse = 1'b1;
            pc_ctrl     = pc_sel_q;
            if (en) begin
               en_group_pulse = 1'b1;
               state_d        = StFetch;
            end else begin
               state_d = StIdle;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

endmodule
